// File: rtl/r2r_dac_pkg.sv
// Shared definitions for the R2R ladder sample player: mode encoding,
// midscale code and FIFO level width helpers.
package r2r_dac_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_PLAY = 2'b01,
    MODE_MUTE = 2'b10,
    MODE_RAMP = 2'b11
  } mode_e;

  function automatic int midscale(input int dac_w);
    return 1 << (dac_w - 1);
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/r2r_sample_fifo.sv
// DEPTH x DAC_W sample FIFO with push, pop, synchronous flush and occupancy.
// Head data is the stored word at the read pointer; there is no fall-through.
module r2r_sample_fifo
  import r2r_dac_pkg::*;
#(
  parameter int DAC_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DAC_W-1:0]            data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [DAC_W-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DAC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  // Flush shares the reset path: pointers and occupancy return to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/r2r_dac_sample_player.sv
// Sample player front end for the R2R ladder DAC: FIFO, tick divider and
// mode control. Optional ramp generator enabled by R2R_DAC_RAMP_GEN_EN.
module r2r_dac_sample_player
  import r2r_dac_pkg::*;
#(
  parameter int DAC_W = 8,
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [1:0]                  mode,
  input  logic [DIV_W-1:0]            div,
  input  logic                        wr_valid,
  input  logic [DAC_W-1:0]            wr_data,
  output logic                        wr_ready,
  input  logic                        clr_underrun,
  output logic [DAC_W-1:0]            dac_code,
  output logic                        update,
  output logic                        underrun,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

  mode_e            eff_mode;
  logic [DIV_W-1:0] cnt;
  logic             counting;
  logic             tick;
  logic             play_tick;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DAC_W-1:0] fifo_head;
  logic             push;
  logic             pop;

  always_comb begin
    eff_mode = ena ? mode_e'(mode) : MODE_IDLE;
`ifndef R2R_DAC_RAMP_GEN_EN
    if (eff_mode == MODE_RAMP) eff_mode = MODE_IDLE;
`endif
  end

  assign counting  = (eff_mode == MODE_PLAY) || (eff_mode == MODE_RAMP);
  assign tick      = counting && (cnt == div);
  assign play_tick = (eff_mode == MODE_PLAY) && tick;

  // Valid/ready: a sample is taken on any edge where wr_valid && wr_ready.
  assign wr_ready = !fifo_full && (eff_mode != MODE_MUTE);
  assign push     = wr_valid && wr_ready;
  assign pop      = play_tick && !fifo_empty;

  r2r_sample_fifo #(
    .DAC_W(DAC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .data (wr_data),
    .pop  (pop),
    .flush(eff_mode == MODE_MUTE),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      dac_code <= MID;
      update   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // A div lowered below cnt simply lets the counter wrap around.
      if (!counting || tick) cnt <= '0;
      else                   cnt <= cnt + DIV_W'(1);

      update <= 1'b0;
      case (eff_mode)
        MODE_MUTE: dac_code <= MID;
        MODE_PLAY: begin
          if (pop) begin
            dac_code <= fifo_head;
            update   <= 1'b1;
          end
        end
`ifdef R2R_DAC_RAMP_GEN_EN
        MODE_RAMP: begin
          if (tick) begin
            dac_code <= dac_code + DAC_W'(1);
            update   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase

      // Setting wins over a simultaneous clear request.
      if (play_tick && fifo_empty) underrun <= 1'b1;
      else if (clr_underrun)       underrun <= 1'b0;
    end
  end

endmodule
